// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction fetch stage feeding the ISA datapath.
// Holds a loadable 2^AW x IW program memory, walks a program counter through it
// and delivers each instruction through a 2-entry valid/ready buffer. Stops on a
// HALT word (all zeros) or after the last address, then reports completion.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse, begins fetching at address 0 (IDLE/DONE)
//   abort             synchronous flush back to IDLE, highest priority
//   prog_we/dir/dato  program memory write port (honoured in IDLE/DONE only)
//   instruccion       head of the output buffer
//   inst_valid        instruccion holds a valid instruction
//   inst_ready        downstream accepts instruccion this cycle
//   pc                address of the next read to issue
//   busy              high in FETCH and DRAIN
//   done              high in DONE
module unidad_fetch #(
  parameter int unsigned IW = 20,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_dir,
  input  logic [IW-1:0] prog_dato,
  output logic [IW-1:0] instruccion,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_nx;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] mem_q;
  logic          rd_valid;
  logic [IW-1:0] buf1;
  logic [CW-1:0] cnt, cnt_nx;

  logic idle_c, start_c, pop_c, push_c, halt_c, issue_c, last_c, drained_c, wr_c;
  logic [2:0] occ_c, lim_c;

  // Next-state and control decode
  always_comb begin
    state_nx  = state;
    idle_c    = (state == S_IDLE) || (state == S_DONE);
    start_c   = start && !abort && idle_c;
    wr_c      = prog_we && !abort && idle_c;
    pop_c     = (cnt != '0) && inst_ready;
    halt_c    = rd_valid && (mem_q == '0);
    push_c    = rd_valid && (mem_q != '0);
    // Reads in flight count against buffer space so the buffer can never overflow
    occ_c     = 3'(cnt) + 3'(rd_valid);
    lim_c     = 3'd2 + 3'(pop_c);
    issue_c   = (state == S_FETCH) && !abort && (occ_c < lim_c);
    last_c    = issue_c && (pc == {AW{1'b1}});
    // Empty after this edge, so done rises on the edge of the final pop
    drained_c = !rd_valid && ((cnt == '0) || ((cnt == CW'(1)) && pop_c));
    cnt_nx    = cnt + CW'(push_c) - CW'(pop_c);
    if (abort || start_c) begin
      cnt_nx = '0;
    end

    case (state)
      S_IDLE, S_DONE: if (start_c) state_nx = S_FETCH;
      S_FETCH:        if (halt_c || last_c) state_nx = S_DRAIN;
      S_DRAIN:        if (drained_c) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx = S_IDLE;
    end
  end

  // State register and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_FETCH) || (state_nx == S_DRAIN);
      done  <= (state_nx == S_DONE);
    end
  end

  // Program memory: synchronous write, registered read; contents not reset
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[prog_dir] <= prog_dato;
    end
    if (issue_c) begin
      mem_q <= mem[pc];
    end
  end

  // Program counter, read tracking and 2-entry output buffer (head = instruccion)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      rd_valid    <= 1'b0;
      cnt         <= '0;
      instruccion <= '0;
      buf1        <= '0;
      inst_valid  <= 1'b0;
    end else if (abort || start_c) begin
      pc          <= '0;
      rd_valid    <= 1'b0;
      cnt         <= '0;
      instruccion <= '0;
      buf1        <= '0;
      inst_valid  <= 1'b0;
    end else begin
      if (issue_c) begin
        pc <= pc + AW'(1);
      end
      // A read issued alongside a returning HALT is squashed
      rd_valid   <= issue_c && !halt_c;
      cnt        <= cnt_nx;
      inst_valid <= (cnt_nx != '0);
      case ({push_c, pop_c})
        2'b10: begin
          if (cnt == '0) instruccion <= mem_q;
          else           buf1        <= mem_q;
        end
        2'b01: instruccion <= buf1;
        2'b11: begin
          if (cnt == CW'(1)) begin
            instruccion <= mem_q;
          end else begin
            instruccion <= buf1;
            buf1        <= mem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_fetch.sv
module tb_unidad_fetch;

  localparam int unsigned IW = 20;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          prog_we;
  logic [AW-1:0] prog_dir;
  logic [IW-1:0] prog_dato;
  logic [IW-1:0] instruccion;
  logic          inst_valid;
  logic          inst_ready;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  unidad_fetch #(.IW(IW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_dir(prog_dir), .prog_dato(prog_dato),
    .instruccion(instruccion), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs driven and outputs sampled 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    prog_we   = 1'b1;
    prog_dir  = AW'(a);
    prog_dato = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 60) begin
      step();
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr"}, 32'(instruccion), 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_pc"},    32'(pc),         32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    prog_dir = '0; prog_dato = '0; inst_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    #10;
    rst = 1'b0;
    step();

    // Program 1..5 then HALT at address 5
    for (int i = 0; i < 5; i++) load(i, IW'(i + 1));
    load(5, 20'h00000);

    // Run with ready high: transfers in consecutive cycles from cycle after E2
    inst_ready = 1'b1;
    pulse_start();
    chk("run_busy", 32'(busy), 32'd1);
    step();
    chk("run_lat_valid", 32'(inst_valid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("run_valid", 32'(inst_valid), 32'd1);
      chk("run_instr", 32'(instruccion), 32'(k));
    end
    step();
    chk("run_no_halt_xfer", 32'(inst_valid), 32'd0);
    wait_done("run_done");
    chk("run_done_valid", 32'(inst_valid), 32'd0);
    chk("run_done_busy", 32'(busy), 32'd0);

    // Backpressure: ready low for 6 cycles after first valid
    inst_ready = 1'b0;
    pulse_start();
    step();
    step();
    for (int k = 0; k < 6; k++) begin
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_instr", 32'(instruccion), 32'h1);
      step();
    end
    chk("bp_occupancy", 32'(dut.cnt), 32'd2);
    inst_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("bp_order_valid", 32'(inst_valid), 32'd1);
      chk("bp_order_instr", 32'(instruccion), 32'(k));
    end
    step();
    chk("bp_tail_valid", 32'(inst_valid), 32'd0);
    wait_done("bp_done");

    // Abort with two words buffered
    inst_ready = 1'b0;
    pulse_start();
    step();
    step();
    step();
    chk("ab_occupancy", 32'(dut.cnt), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", 32'(inst_valid), 32'd0);
    chk("ab_pc", 32'(pc), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    inst_ready = 1'b1;
    pulse_start();
    step();
    step();
    chk("ab_restart_valid", 32'(inst_valid), 32'd1);
    chk("ab_restart_instr", 32'(instruccion), 32'h1);
    wait_done("ab_done_after");

    // Write protection while busy
    pulse_start();
    prog_we = 1'b1; prog_dir = AW'(3); prog_dato = 20'hABCDE;
    step();
    prog_we = 1'b0;
    wait_done("wp_first_done");
    pulse_start();
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("wp_instr", 32'(instruccion), 32'(k));
    end
    wait_done("wp_done");

    // No HALT: 32 nonzero words, last transfer in cycle 33, done one later
    for (int i = 0; i < 32; i++) load(i, IW'(32'h10000 + i));
    pulse_start();
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k == 1) begin
        chk("nh_lat_valid", 32'(inst_valid), 32'd0);
      end else begin
        chk("nh_valid", 32'(inst_valid), 32'd1);
        chk("nh_instr", 32'(instruccion), 32'h10000 + 32'(k - 2));
      end
    end
    chk("nh_done_early", 32'(done), 32'd0);
    step();
    chk("nh_done", 32'(done), 32'd1);
    chk("nh_empty", 32'(inst_valid), 32'd0);
    chk("nh_pc_wrap", 32'(pc), 32'd0);

    // Asynchronous reset between edges during FETCH
    pulse_start();
    step();
    step();
    step();
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("ar");
    rst = 1'b0;
    step();
    step();
    chk("ar_stays_idle", 32'(busy), 32'd0);
    chk("ar_stays_invalid", 32'(inst_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
